// File: rtl/i2c_ads1115_responder.sv
// i2c_ads1115_responder: I2C target emulating the ADS1115 register map.
// Conversion value comes from fabric; config writes are reported back.
module i2c_ads1115_responder #(
    parameter logic [6:0]  DEV_ADDR    = 7'h48,
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] CFG_RESET   = 16'h8583
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    input  logic [15:0] conv_value,
    output logic [15:0] config_reg,
    output logic        config_wr,
    output logic [1:0]  pointer,
    output logic        busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_PTR,
        S_PTR_ACK,
        S_WR_MSB,
        S_WR_MSB_ACK,
        S_WR_LSB,
        S_WR_LSB_ACK,
        S_RD_BYTE,
        S_RD_ACK,
        S_WAIT_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;

    logic scl_s;
    logic sda_s;
    logic start_det;
    logic stop_det;
    logic scl_rise;
    logic scl_fall;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [7:0]  sh_q;
    logic [7:0]  msb_q;
    logic [15:0] rd_q;
    logic        sel_q;
    logic        rw_q;
    logic        ack_q;
    logic        oe_q;
    logic [1:0]  ptr_q;
    logic [15:0] cfg_q;
    logic [15:0] lo_q;
    logic [15:0] hi_q;
    logic        cfg_wr_q;
    logic [15:0] rd_mux;

    // Bring the bus pins into the clk domain and keep the last synced level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;

    // Register read mux; pointer 0 is the live fabric conversion value.
    always_comb begin
        rd_mux = conv_value;
        unique case (ptr_q)
            2'd0: rd_mux = conv_value;
            2'd1: rd_mux = cfg_q;
            2'd2: rd_mux = lo_q;
            2'd3: rd_mux = hi_q;
            default: rd_mux = conv_value;
        endcase
    end

    // Protocol FSM: sample on SCL rise, drive SDA on SCL fall, START/STOP win.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            sh_q     <= 8'd0;
            msb_q    <= 8'd0;
            rd_q     <= 16'd0;
            sel_q    <= 1'b0;
            rw_q     <= 1'b0;
            ack_q    <= 1'b1;
            oe_q     <= 1'b0;
            ptr_q    <= 2'd0;
            cfg_q    <= CFG_RESET;
            lo_q     <= 16'h8000;
            hi_q     <= 16'h7FFF;
            cfg_wr_q <= 1'b0;
        end else begin
            cfg_wr_q <= 1'b0;
            if (start_det) begin
                state_q <= S_ADDR;
                cnt_q   <= 4'd0;
                oe_q    <= 1'b0;
                sel_q   <= 1'b0;
            end else if (stop_det) begin
                state_q <= S_IDLE;
                oe_q    <= 1'b0;
            end else if (scl_rise) begin
                case (state_q)
                    S_ADDR, S_PTR, S_WR_MSB, S_WR_LSB, S_RD_BYTE: begin
                        if (cnt_q != 4'd8) begin
                            sh_q  <= {sh_q[6:0], sda_s};
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                    S_RD_ACK: ack_q <= sda_s;
                    S_WR_LSB_ACK: begin
                        unique case (ptr_q)
                            2'd0: ;
                            2'd1: begin
                                cfg_q    <= {msb_q, sh_q};
                                cfg_wr_q <= 1'b1;
                            end
                            2'd2: lo_q <= {msb_q, sh_q};
                            2'd3: hi_q <= {msb_q, sh_q};
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end else if (scl_fall) begin
                case (state_q)
                    S_ADDR: begin
                        if (cnt_q == 4'd8) begin
                            if (sh_q[7:1] == DEV_ADDR && sh_q[7:1] != 7'd0) begin
                                state_q <= S_ADDR_ACK;
                                oe_q    <= 1'b1;
                                rw_q    <= sh_q[0];
                            end else begin
                                state_q <= S_WAIT_STOP;
                                oe_q    <= 1'b0;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        cnt_q <= 4'd0;
                        if (rw_q) begin
                            rd_q    <= rd_mux;
                            sel_q   <= 1'b0;
                            oe_q    <= ~rd_mux[15];
                            state_q <= S_RD_BYTE;
                        end else begin
                            oe_q    <= 1'b0;
                            state_q <= S_PTR;
                        end
                    end
                    S_PTR: begin
                        if (cnt_q == 4'd8) begin
                            ptr_q   <= sh_q[1:0];
                            oe_q    <= 1'b1;
                            state_q <= S_PTR_ACK;
                        end
                    end
                    S_PTR_ACK, S_WR_LSB_ACK: begin
                        oe_q    <= 1'b0;
                        cnt_q   <= 4'd0;
                        state_q <= S_WR_MSB;
                    end
                    S_WR_MSB: begin
                        if (cnt_q == 4'd8) begin
                            msb_q   <= sh_q;
                            oe_q    <= 1'b1;
                            state_q <= S_WR_MSB_ACK;
                        end
                    end
                    S_WR_MSB_ACK: begin
                        oe_q    <= 1'b0;
                        cnt_q   <= 4'd0;
                        state_q <= S_WR_LSB;
                    end
                    S_WR_LSB: begin
                        if (cnt_q == 4'd8) begin
                            oe_q    <= 1'b1;
                            state_q <= S_WR_LSB_ACK;
                        end
                    end
                    S_RD_BYTE: begin
                        if (cnt_q == 4'd8) begin
                            oe_q    <= 1'b0;
                            state_q <= S_RD_ACK;
                        end else begin
                            oe_q <= ~rd_q[{~sel_q, ~cnt_q[2:0]}];
                        end
                    end
                    S_RD_ACK: begin
                        cnt_q <= 4'd0;
                        if (ack_q) begin
                            oe_q    <= 1'b0;
                            state_q <= S_WAIT_STOP;
                        end else if (!sel_q) begin
                            sel_q   <= 1'b1;
                            oe_q    <= ~rd_q[7];
                            state_q <= S_RD_BYTE;
                        end else begin
                            rd_q    <= rd_mux;
                            sel_q   <= 1'b0;
                            oe_q    <= ~rd_mux[15];
                            state_q <= S_RD_BYTE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda_oe     = oe_q;
    assign config_reg = cfg_q;
    assign config_wr  = cfg_wr_q;
    assign pointer    = ptr_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_i2c_ads1115_responder.sv
// tb_i2c_ads1115_responder: bus-level master driving directed transfers.
// Expected values are queued by the stimulus and compared by a monitor.
`timescale 1ns/1ps
module tb_i2c_ads1115_responder;

    localparam int Q = 100;

    typedef struct {
        string       name;
        logic [15:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        scl;
    logic        sda_m;
    logic        sda_bus;
    logic        sda_oe;
    logic [15:0] conv;
    logic [15:0] config_reg;
    logic        config_wr;
    logic [1:0]  pointer;
    logic        busy;

    exp_t        exp_q[$];
    logic [15:0] act_q[$];
    int          tests = 0;
    int          fails = 0;
    int          wr_cnt = 0;
    int          oe_cnt = 0;
    bit          done = 1'b0;
    int          wc0;
    int          oc0;

    always #5 clk = ~clk;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_ads1115_responder dut (
        .clk        (clk),
        .reset      (rst_n),
        .scl_i      (scl),
        .sda_i      (sda_bus),
        .sda_oe     (sda_oe),
        .conv_value (conv),
        .config_reg (config_reg),
        .config_wr  (config_wr),
        .pointer    (pointer),
        .busy       (busy)
    );

    // Activity counters for pulses and SDA drive.
    always @(posedge clk) begin
        if (config_wr) wr_cnt <= wr_cnt + 1;
        if (sda_oe) oe_cnt <= oe_cnt + 1;
    end

    task automatic expect_v(input string n, input logic [15:0] v);
        exp_t e;
        e.name = n;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic probe(input string n, input logic [15:0] v,
                         input logic [15:0] act);
        expect_v(n, v);
        act_q.push_back(act);
    endtask

    task automatic start_c();
        sda_m = 1'b1; #(Q);
        scl = 1'b1;   #(Q);
        sda_m = 1'b0; #(Q);
        scl = 1'b0;   #(Q);
    endtask

    task automatic stop_c();
        sda_m = 1'b0; #(Q);
        scl = 1'b1;   #(Q);
        sda_m = 1'b1; #(Q);
    endtask

    task automatic wbyte(input logic [7:0] b, input string n,
                         input logic exp_ack);
        expect_v(n, {15'd0, exp_ack});
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; #(Q);
            scl = 1'b1;   #(2*Q);
            scl = 1'b0;   #(Q);
        end
        sda_m = 1'b1; #(Q);
        scl = 1'b1;   #(Q);
        act_q.push_back({15'd0, sda_bus});
        #(Q);
        scl = 1'b0;   #(Q);
    endtask

    task automatic rbyte(input logic nack, input string n,
                         input logic [7:0] exp_b);
        logic [7:0] b;
        b = 8'd0;
        expect_v(n, {8'd0, exp_b});
        sda_m = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #(Q);
            scl = 1'b1; #(Q);
            b = {b[6:0], sda_bus};
            #(Q);
            scl = 1'b0;
        end
        act_q.push_back({8'd0, b});
        #(Q);
        sda_m = nack; #(Q);
        scl = 1'b1;   #(2*Q);
        scl = 1'b0;   #(Q);
    endtask

    // Scoreboard monitor: pairs each observed value with the queued expectation.
    initial begin
        logic [15:0] a;
        exp_t        e;
        forever begin
            @(negedge clk);
            while (act_q.size() > 0) begin
                a = act_q.pop_front();
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected: got %h, nothing expected", a);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e.val) begin
                        fails++;
                        $display("FAIL %s: got %h, expected %h",
                                 e.name, a, e.val);
                    end
                end
            end
            if (done) begin
                while (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    tests++;
                    fails++;
                    $display("FAIL %s: got nothing, expected %h",
                             e.name, e.val);
                end
                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $finish;
            end
        end
    end

    initial begin
        #(3ms);
        $display("FAIL watchdog: simulation did not finish, expected done");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        scl   = 1'b1;
        sda_m = 1'b1;
        conv  = 16'h1234;
        repeat (5) @(posedge clk);
        #1;
        probe("rst_sda_oe", 16'd0, {15'd0, sda_oe});
        probe("rst_config", 16'h8583, config_reg);
        probe("rst_config_wr", 16'd0, {15'd0, config_wr});
        probe("rst_pointer", 16'd0, {14'd0, pointer});
        probe("rst_busy", 16'd0, {15'd0, busy});
        rst_n = 1'b1;
        repeat (10) @(posedge clk);

        start_c();
        wbyte(8'h90, "conv_addr_ack", 1'b0);
        wbyte(8'h00, "conv_ptr_ack", 1'b0);
        start_c();
        wbyte(8'h91, "conv_raddr_ack", 1'b0);
        rbyte(1'b0, "conv_msb", 8'h12);
        rbyte(1'b1, "conv_lsb", 8'h34);
        stop_c();
        repeat (10) @(posedge clk);
        probe("conv_pointer", 16'd0, {14'd0, pointer});
        probe("conv_busy", 16'd0, {15'd0, busy});

        wc0 = wr_cnt;
        start_c();
        wbyte(8'h90, "cfg_addr_ack", 1'b0);
        wbyte(8'h01, "cfg_ptr_ack", 1'b0);
        wbyte(8'hC3, "cfg_msb_ack", 1'b0);
        wbyte(8'h85, "cfg_lsb_ack", 1'b0);
        stop_c();
        repeat (10) @(posedge clk);
        probe("cfg_value", 16'hC385, config_reg);
        probe("cfg_wr_pulses", 16'd1, 16'(wr_cnt - wc0));
        start_c();
        wbyte(8'h91, "cfg_raddr_ack", 1'b0);
        rbyte(1'b0, "cfg_rd_msb", 8'hC3);
        rbyte(1'b1, "cfg_rd_lsb", 8'h85);
        stop_c();

        wc0 = wr_cnt;
        oc0 = oe_cnt;
        start_c();
        wbyte(8'h92, "mis_addr_nack", 1'b1);
        wbyte(8'h02, "mis_b1_nack", 1'b1);
        wbyte(8'hAA, "mis_b2_nack", 1'b1);
        wbyte(8'h55, "mis_b3_nack", 1'b1);
        stop_c();
        start_c();
        wbyte(8'h00, "gcall_nack", 1'b1);
        stop_c();
        repeat (10) @(posedge clk);
        probe("mis_sda_oe", 16'd0, 16'(oe_cnt - oc0));
        probe("mis_pointer", 16'd1, {14'd0, pointer});
        probe("mis_config", 16'hC385, config_reg);
        probe("mis_cfg_wr", 16'd0, 16'(wr_cnt - wc0));

        start_c();
        wbyte(8'h90, "wrap_addr_ack", 1'b0);
        wbyte(8'h03, "wrap_ptr_ack", 1'b0);
        stop_c();
        start_c();
        wbyte(8'h91, "wrap_raddr_ack", 1'b0);
        rbyte(1'b0, "wrap_b0", 8'h7F);
        rbyte(1'b0, "wrap_b1", 8'hFF);
        rbyte(1'b0, "wrap_b2", 8'h7F);
        rbyte(1'b1, "wrap_b3", 8'hFF);
        stop_c();
        probe("wrap_pointer", 16'd3, {14'd0, pointer});

        start_c();
        wbyte(8'h90, "snap_addr_ack", 1'b0);
        wbyte(8'h00, "snap_ptr_ack", 1'b0);
        stop_c();
        conv = 16'h00FF;
        start_c();
        wbyte(8'h91, "snap_raddr_ack", 1'b0);
        rbyte(1'b0, "snap_msb", 8'h00);
        conv = 16'hFF00;
        rbyte(1'b1, "snap_lsb", 8'hFF);
        stop_c();

        wc0 = wr_cnt;
        start_c();
        wbyte(8'h90, "abort_addr_ack", 1'b0);
        wbyte(8'h01, "abort_ptr_ack", 1'b0);
        wbyte(8'h12, "abort_msb_ack", 1'b0);
        stop_c();
        repeat (10) @(posedge clk);
        probe("abort_config", 16'hC385, config_reg);
        probe("abort_cfg_wr", 16'd0, 16'(wr_cnt - wc0));

        start_c();
        wbyte(8'h90, "rst_t_addr_ack", 1'b0);
        wbyte(8'h00, "rst_t_ptr_ack", 1'b0);
        stop_c();
        conv = 16'h0000;
        start_c();
        wbyte(8'h91, "rst_t_raddr_ack", 1'b0);
        probe("rd_bit_drive", 16'd1, {15'd0, sda_oe});
        rst_n = 1'b0;
        #1;
        probe("rst_async_oe", 16'd0, {15'd0, sda_oe});
        probe("rst_async_busy", 16'd0, {15'd0, busy});
        probe("rst_async_cfg", 16'h8583, config_reg);
        #(Q);
        rst_n = 1'b1;
        scl   = 1'b1;
        sda_m = 1'b1;
        repeat (20) @(posedge clk);
        probe("post_rst_busy", 16'd0, {15'd0, busy});
        probe("post_rst_oe", 16'd0, {15'd0, sda_oe});

        repeat (5) @(posedge clk);
        done = 1'b1;
    end

endmodule
